seq_alu: RTL
============

# seq_alu

Parametrised multi-cycle ALU, successor to the datapath's fixed 32-bit ALU. Performs logic, add/sub, shift/rotate and negate in one cycle, signed multiply via radix-4 Booth and signed divide via non-restoring division over multiple cycles. Uses a start/busy/done handshake so the control unit can stall on long operations. Sits between the A/B operand registers and the HI/LO and Z result registers of the CPU datapath.

## Interface

- Clocking and reset (already decided): one clock, `clk`; reset `clear` is asynchronous and active-high.

Parameters:

- WIDTH, 32: operand width. Must be even and ≥4.
- SHW, $clog2(WIDTH): shift-amount bits taken from B.

Ports:

- clk  in  1  clock, rising edge.
- clear  in  1  asynchronous active-high reset.
- start  in  1  request; sampled only in IDLE.
- signal  in  5  opcode, latched on accepted start.
- A  in  WIDTH  operand A / data / dividend, latched on start.
- B  in  WIDTH  operand B / shift amount / divisor, latched on start.
- Result  out  2*WIDTH  registered result, held until the next done.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse; Result is valid from this cycle.
- div_zero  out  1  set with done when DIV had B==0; cleared on the next accepted start.
- illegal  out  1  set with done for an undefined opcode; cleared on the next accepted start.

## Operation

- Opcodes: 00000 AND, 00001 OR, 00010 NOT A, 00011 ADD, 00100 SUB (A−B), 00101 MUL, 00110 DIV, 00111 SHL, 01000 SHR, 01001 SHRA, 01010 ROL, 01011 ROR, 01100 NEG A. All others are illegal: Result=0, illegal=1, single-cycle.
- Single-width ops: Result[WIDTH-1:0]=value, Result[2W-1:WIDTH]=0. ADD/SUB/NEG wrap modulo 2^WIDTH with no carry out.
- Shifts and rotates: A is the data; the amount is B[SHW-1:0], so upper bits of B are ignored. SHRA replicates A's MSB. An amount of 0 passes A through.
- MUL: signed × signed, full 2*WIDTH product.
- DIV: signed division truncating toward zero.
  - Result[WIDTH-1:0] = quotient; Result[2W-1:WIDTH] = remainder.
  - The remainder takes the sign of the dividend.
  - B==0: no iteration; quotient is all-ones, remainder is A, div_zero=1.
  - Most-negative ÷ −1: quotient is the most-negative value, remainder 0. No flag.
- FSM states: IDLE, MUL, DIV, FIX, DONE.
  - IDLE+start, single-cycle op or DIV with B==0 → DONE.
  - IDLE+start, MUL → MUL. IDLE+start, DIV → DIV.
  - MUL counts WIDTH/2 iterations → DONE.
  - DIV counts WIDTH iterations → FIX. FIX does the remainder restore and sign correction → DONE.
  - DONE → IDLE unconditionally.
- Iteration counter is SHW bits and is loaded at start.

## Timing

- Edge 0: start accepted in IDLE.
- Single-cycle ops: Result, done=1 and flags are registered at edge 1. busy is never asserted.
- MUL: busy=1 from edge 1. Result and done at edge WIDTH/2+1, which is edge 17 for WIDTH=32.
- DIV: busy=1 from edge 1. Result and done at edge WIDTH+2, which is edge 34 for WIDTH=32.
- busy drops in the same edge that done rises. done is high for exactly one cycle.
- A new start is accepted in the cycle done is high (state DONE→IDLE counts as IDLE for acceptance), so back-to-back single-cycle ops complete every 2 cycles.
- start while busy is ignored, and changes to A, B or signal mid-operation have no effect.
- Reset values: Result=0, busy=0, done=0, div_zero=0, illegal=0, state=IDLE.
- clear asserted mid-operation aborts immediately. Outputs take reset values, and no done is ever produced for the aborted op.

## Structure

- Shared package/header `alu_defs`: opcode constants (ALU_AND … ALU_NEG) and the FSM state encoding. The control unit uses the same opcode constants.
- One natural sub-module: `div_nr_unit` (non-restoring divider datapath: partial remainder, quotient shift, final restore, sign fix), parametrised by WIDTH.
- Booth multiply, the shifter and the logic ops stay in `seq_alu`.

## Test plan

All scenarios use WIDTH=32.

- ADD A=1, B=1 → at edge 1: Result=64'h2, done pulses once, busy stays 0. SUB A=5, B=2 → Result=64'h3.
- MUL A=2, B=3 → Result=64'h6 at edge 17. MUL A=−3, B=7 → Result=64'hFFFF_FFFF_FFFF_FFEB. busy is high for edges 1–16.
- DIV A=−16, B=16 → Result=64'h0000_0000_FFFF_FFFF at edge 34. DIV A=17, B=5 → 64'h0000_0002_0000_0003. DIV A=−17, B=5 → remainder 32'hFFFF_FFFE, quotient 32'hFFFF_FFFD.
- DIV A=7, B=0 → edge 1: Result=64'h0000_0007_FFFF_FFFF, div_zero=1. The next ADD clears div_zero.
- ROR A=32'h8000_0000, B=2 → 32'h2000_0000. SHRA A=32'h8000_0000, B=4 → 32'hF800_0000. SHL A=1, B=33 → 32'h2. Opcode 5'b11111 → illegal=1, Result=0.
- Start DIV, then pulse start with MUL at edge 5 → ignored and the DIV result is unchanged. Start DIV, then assert clear at edge 10 → all outputs 0 and no done afterwards. A fresh ADD after clear releases completes normally.

Source files
------------

// File: rtl/alu_defs_pkg.sv
// alu_defs: opcode constants and FSM state encoding shared by seq_alu and the control unit
package alu_defs;
    localparam logic [4:0] ALU_AND  = 5'd0;
    localparam logic [4:0] ALU_OR   = 5'd1;
    localparam logic [4:0] ALU_NOT  = 5'd2;
    localparam logic [4:0] ALU_ADD  = 5'd3;
    localparam logic [4:0] ALU_SUB  = 5'd4;
    localparam logic [4:0] ALU_MUL  = 5'd5;
    localparam logic [4:0] ALU_DIV  = 5'd6;
    localparam logic [4:0] ALU_SHL  = 5'd7;
    localparam logic [4:0] ALU_SHR  = 5'd8;
    localparam logic [4:0] ALU_SHRA = 5'd9;
    localparam logic [4:0] ALU_ROL  = 5'd10;
    localparam logic [4:0] ALU_ROR  = 5'd11;
    localparam logic [4:0] ALU_NEG  = 5'd12;

    typedef enum logic [2:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX, ST_DONE} state_t;

    function automatic logic is_legal(input logic [4:0] op);
        return op <= ALU_NEG;
    endfunction
endpackage

// File: rtl/div_nr_unit.sv
// div_nr_unit: signed non-restoring divider on operand magnitudes, with final restore and sign fix
module div_nr_unit
    import alu_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load,
    input  logic             step,
    input  logic             fix,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    // two guard bits: shifted partial remainder can reach 2*|divisor|+1 with |divisor| up to 2^(W-1)
    logic [WIDTH+1:0] rem;
    logic [WIDTH+1:0] rem_sh;
    logic [WIDTH+1:0] rem_nx;
    logic [WIDTH+1:0] rem_fix;
    logic [WIDTH+1:0] d_ext;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic             neg_q;
    logic             neg_r;

    assign d_ext   = {2'b00, dvs};
    assign rem_sh  = {rem[WIDTH:0], quo[WIDTH-1]};
    assign rem_nx  = rem[WIDTH+1] ? rem_sh + d_ext : rem_sh - d_ext;
    assign rem_fix = rem[WIDTH+1] ? rem + d_ext : rem;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (load) begin
            rem   <= '0;
            quo   <= a[WIDTH-1] ? -a : a;
            dvs   <= b[WIDTH-1] ? -b : b;
            neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_r <= a[WIDTH-1];
        end else if (step) begin
            rem <= rem_nx;
            quo <= {quo[WIDTH-2:0], ~rem_nx[WIDTH+1]};
        end else if (fix) begin
            rem <= neg_r ? -rem_fix : rem_fix;
            quo <= neg_q ? -quo : quo;
        end
    end

    assign quotient  = quo;
    assign remainder = rem[WIDTH-1:0];
endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with single-cycle logic/arith/shift ops, radix-4 Booth multiply
// and non-restoring divide behind a start/busy/done handshake.
module seq_alu
    import alu_defs::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               start,
    input  logic [4:0]         signal,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic [2*WIDTH-1:0] Result,
    output logic               busy,
    output logic               done,
    output logic               div_zero,
    output logic               illegal
);
    state_t               state;
    state_t               state_nx;
    logic [4:0]           op_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [SHW-1:0]       cnt;
    logic                 accept;
    logic                 b_zero;
    logic [SHW-1:0]       amt;
    logic [SHW:0]         inv_amt;
    logic [WIDTH-1:0]     single;
    logic [2*WIDTH-1:0]   res_nx;
    logic [WIDTH-1:0]     quotient;
    logic [WIDTH-1:0]     remainder;
    // Booth register: {acc[W+1:0], multiplier[W-1:0], q_minus1}
    logic [2*WIDTH+2:0]   mul_reg;
    logic [2*WIDTH+2:0]   mul_nx;
    logic [WIDTH+1:0]     m_ext;
    logic [WIDTH+1:0]     pp;
    logic [WIDTH+1:0]     mul_sum;

    assign accept  = (state == ST_IDLE) && start;
    assign b_zero  = (b_q == '0);
    assign amt     = b_q[SHW-1:0];
    assign inv_amt = (SHW+1)'(WIDTH) - {1'b0, amt};

    div_nr_unit #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .clear     (clear),
        .load      (accept && signal == ALU_DIV),
        .step      (state == ST_DIV),
        .fix       (state == ST_FIX),
        .a         (A),
        .b         (B),
        .quotient  (quotient),
        .remainder (remainder)
    );

    assign m_ext = {{2{a_q[WIDTH-1]}}, a_q};

    always_comb begin
        pp = '0;
        case (mul_reg[2:0])
            3'b001, 3'b010: pp = m_ext;
            3'b011:         pp = m_ext << 1;
            3'b100:         pp = -(m_ext << 1);
            3'b101, 3'b110: pp = -m_ext;
            default:        pp = '0;
        endcase
        mul_sum = mul_reg[2*WIDTH+2:WIDTH+1] + pp;
        mul_nx  = {{2{mul_sum[WIDTH+1]}}, mul_sum, mul_reg[WIDTH:2]};
    end

    always_comb begin
        single = '0;
        case (op_q)
            ALU_AND:  single = a_q & b_q;
            ALU_OR:   single = a_q | b_q;
            ALU_NOT:  single = ~a_q;
            ALU_ADD:  single = a_q + b_q;
            ALU_SUB:  single = a_q - b_q;
            ALU_SHL:  single = a_q << amt;
            ALU_SHR:  single = a_q >> amt;
            ALU_SHRA: single = $signed(a_q) >>> amt;
            ALU_ROL:  single = (a_q << amt) | (a_q >> inv_amt);
            ALU_ROR:  single = (a_q >> amt) | (a_q << inv_amt);
            ALU_NEG:  single = -a_q;
            default:  single = '0;
        endcase
    end

    always_comb begin
        res_nx = op_q == ALU_MUL ? mul_reg[2*WIDTH:1] :
                 op_q == ALU_DIV ? (b_zero ? {a_q, {WIDTH{1'b1}}} : {remainder, quotient}) :
                 {{WIDTH{1'b0}}, single};
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start) state_nx = signal == ALU_MUL ? ST_MUL :
                                           (signal == ALU_DIV && B != '0) ? ST_DIV : ST_DONE;
            ST_MUL:  state_nx = cnt == '0 ? ST_DONE : ST_MUL;
            ST_DIV:  state_nx = cnt == '0 ? ST_FIX : ST_DIV;
            ST_FIX:  state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state    <= ST_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cnt      <= '0;
            mul_reg  <= '0;
            Result   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= state == ST_MUL || state == ST_DIV || state == ST_FIX;
            done  <= state == ST_DONE;
            if (accept) begin
                op_q     <= signal;
                a_q      <= A;
                b_q      <= B;
                cnt      <= signal == ALU_MUL ? SHW'(WIDTH/2 - 1) : SHW'(WIDTH - 1);
                mul_reg  <= {{(WIDTH+2){1'b0}}, B, 1'b0};
                div_zero <= 1'b0;
                illegal  <= 1'b0;
            end else if (state == ST_MUL) begin
                mul_reg <= mul_nx;
                cnt     <= cnt - 1'b1;
            end else if (state == ST_DIV) begin
                cnt <= cnt - 1'b1;
            end
            if (state == ST_DONE) begin
                Result   <= is_legal(op_q) ? res_nx : '0;
                div_zero <= op_q == ALU_DIV && b_zero;
                illegal  <= !is_legal(op_q);
            end
        end
    end
endmodule
